dmem_req: RTL
=============

# dmem_req

Data-memory request initiator for the memory stage: the writing side of the load/store datapath whose read side is the writeback stage's load-data extender. It turns a decoded load/store into one SRAM-like bus transaction: byte-lane aligned store data, byte strobes, and the address/data handshake. It stalls the pipeline while a transaction is outstanding and holds the raw `data_rdata` word until the pipeline advances. Writeback then consumes that word unmodified and does the sign/size extension.

## Interface
Parameters:
- none.

Ports (name, direction, width, meaning). Reset is synchronous and active-high; all state changes on the rising edge of `clk`.
- `clk` in 1: core clock.
- `rst` in 1: synchronous reset, active-high.
- `req_valid` in 1: memory stage holds a load/store.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: `SZ_BYTE`=00, `SZ_HALF`=01, `SZ_WORD`=10.
- `req_addr` in 32: effective address.
- `req_wdata` in 32: unaligned store source register (value in low bits).
- `pipe_adv` in 1: memory stage hands its result to writeback this cycle.
- `flush` in 1: exception/ERET flush of the memory stage.
- `data_req` out 1: bus request.
- `data_wr` out 1: bus write.
- `data_size` out 2: bus size (same encoding as `req_size`).
- `data_addr` out 32: bus address.
- `data_wdata` out 32: lane-replicated store data.
- `data_wstrb` out 4: byte enables.
- `data_addr_ok` in 1: address phase accepted.
- `data_data_ok` in 1: data phase complete.
- `data_rdata` in 32: load data.
- `rdata` out 32: captured load word, held until `pipe_adv`.
- `done` out 1: result valid in HOLD.
- `stall` out 1: freeze the memory stage and everything upstream.
- `adel` out 1: load address error.
- `ades` out 1: store address error.

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD, CANCEL.
- IDLE → ADDR when `req_valid & !flush & !addr_err`. The request fields are latched into bus registers on that edge.
- ADDR: `data_req`=1 with the latched fields.
  - `data_addr_ok` → DATA.
  - `data_addr_ok & data_data_ok` together → HOLD.
  - `flush` without `data_addr_ok` → IDLE; the request is withdrawn.
  - `flush` together with `data_addr_ok` → CANCEL.
- DATA: waits for `data_data_ok`.
  - `data_data_ok` → HOLD; `rdata` is captured for both loads and stores.
  - `flush` → CANCEL.
- CANCEL: waits for `data_data_ok`, discards the data, → IDLE. `done` is never raised.
- HOLD: `done`=1.
  - `pipe_adv` or `flush` → IDLE.
- Store alignment:
  - Byte: `data_wdata`={4{wdata[7:0]}`}, `data_wstrb`=0001<<addr[1:0].
  - Half: `data_wdata`={2{wdata[15:0]}`}, `data_wstrb`=0011<<addr[1:0].
  - Word: `data_wdata` passed through, `data_wstrb`=1111.
  - Loads: `data_wstrb`=0000.
- `data_addr` is the full 32-bit address. The low bits are not cleared, because writeback uses addr[1:0] as the lane offset.
- `stall` = (IDLE & `req_valid` & !`flush` & !`addr_err`) | ADDR | DATA | CANCEL.
- `stall` is 0 in HOLD.

## Timing
- Reset: state IDLE; all outputs 0, including `data_req`, `data_wstrb`, `rdata`, `done`, `stall`, `adel` and `ades`.
- `rst` asserted mid-transaction returns to IDLE immediately. The outstanding `data_data_ok` after reset is ignored, because IDLE ignores `data_data_ok`.
- All bus outputs are registered from state and the latched fields; none depends combinationally on `data_addr_ok` or `data_data_ok`.
- `stall`, `adel` and `ades` are combinational from the request inputs and state.
- Minimum latency, with `addr_ok` and `data_ok` each arriving on the first cycle they can:
  - cycle 0: IDLE accepts the request.
  - cycle 1: ADDR (`data_req`=1) with `addr_ok`.
  - cycle 2: DATA with `data_ok`.
  - cycle 3: HOLD, `done`=1.
- Only one outstanding transaction; a new request is never issued from CANCEL.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - `addr_err` = (half & addr[0]) | (word & addr[1:0]≠0).
  - `adel`=`addr_err & !req_we` and `ades`=`addr_err & req_we`; both are valid only while in IDLE with `req_valid`.
  - A misaligned request issues no bus request and does not stall.
- Not defined:
  - `addr_err`, `adel` and `ades` are tied to 0.
  - Every request goes to the bus as given.

## Structure
- The size encodings (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`) and the FSM state enum belong in the shared `cpu_defs` package, alongside the existing stage-boundary structs.
- One sub-module, `store_align`: combinational size + offset + wdata → replicated wdata and wstrb.

## Test plan
- Store byte 0xA5 to 0x8000_0003:
  - `data_wdata`=0xA5A5A5A5, `data_wstrb`=1000, `data_wr`=1, `data_size`=00.
  - With `addr_ok` and `data_ok` each given on the first cycle they are possible, `done` rises at cycle 3.
- Load word from 0x1000 with `addr_ok` delayed 3 cycles and `data_ok` 2 cycles later:
  - `stall`=1 throughout.
  - `rdata`=0xDEADBEEF is held in HOLD until `pipe_adv`.
- `flush` in ADDR before `addr_ok`: `data_req` drops the next cycle, state is IDLE, no `done`.
- `flush` in DATA:
  - CANCEL holds `stall`=1 until `data_ok`, then IDLE with no `done`.
  - A new `req_valid` issues no `data_req` until CANCEL exits.
- With `DMEM_ALIGN_CHECK_EN` defined, a half load at 0x1001: `adel`=1, `data_req` stays 0, `stall`=0.
- With `DMEM_ALIGN_CHECK_EN` undefined, the same half load: `adel`=0, and the bus issues the request with `data_addr`=0x1001.
- `addr_ok` and `data_ok` in the same cycle: ADDR→HOLD directly, and `rdata` is captured that edge.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU definitions: size encodings, data-memory request FSM states and
// the stage-boundary payload latched by the data-memory request initiator.
package cpu_defs;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned DST_W  = 3;

  // Access size, shared by the decode, memory and writeback stages
  typedef logic [SIZE_W-1:0] mem_size_t;
  localparam mem_size_t SZ_BYTE = 2'b00;
  localparam mem_size_t SZ_HALF = 2'b01;
  localparam mem_size_t SZ_WORD = 2'b10;

  // Data-memory request FSM encoding
  typedef logic [DST_W-1:0] dmem_state_t;
  localparam dmem_state_t DST_IDLE   = 3'd0;
  localparam dmem_state_t DST_ADDR   = 3'd1;
  localparam dmem_state_t DST_DATA   = 3'd2;
  localparam dmem_state_t DST_HOLD   = 3'd3;
  localparam dmem_state_t DST_CANCEL = 3'd4;

  // Memory-stage bus payload as driven onto the SRAM-like data bus
  typedef struct packed {
    logic              wr;
    mem_size_t         size;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   wdata;
    logic [STRB_W-1:0] wstrb;
  } dmem_bus_t;

endpackage

// File: rtl/store_align.sv
// Store lane alignment: replicates the store source into every lane of its
// size and derives byte strobes from the address offset. Loads get no strobes.
module store_align
  import cpu_defs::*;
(
  input  logic              we_i,
  input  mem_size_t         size_i,
  input  logic [1:0]        offset_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [STRB_W-1:0] wstrb_o
);

  // Lane replication and strobe shift by access size
  always_comb begin
    wdata_o = wdata_i;
    wstrb_o = '0;
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = STRB_W'(4'b0001 << offset_i);
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = STRB_W'(4'b0011 << offset_i);
      end
      default: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
      end
    endcase
    if (!we_i) wstrb_o = '0;
  end

endmodule

// File: rtl/dmem_req.sv
// Data-memory request initiator: turns a memory-stage load/store into one
// SRAM-like bus transaction, stalls while it is outstanding and holds the raw
// read word for writeback. Optional alignment checking is enabled by defining
// DMEM_ALIGN_CHECK_EN.
module dmem_req
  import cpu_defs::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              pipe_adv,
  input  logic              flush,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [31:0]       data_addr,
  output logic [31:0]       data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              adel,
  output logic              ades
);

  dmem_state_t       state_q, state_d;
  dmem_bus_t         bus_q;
  logic              data_req_q;
  logic              done_q;
  logic [XLEN-1:0]   rdata_q;
  logic              accept_c;
  logic              capture_c;
  logic              addr_err_c;
  logic              idle_req_c;
  logic [XLEN-1:0]   al_wdata_c;
  logic [STRB_W-1:0] al_wstrb_c;

  store_align u_store_align (
    .we_i     (req_we),
    .size_i   (req_size),
    .offset_i (req_addr[1:0]),
    .wdata_i  (req_wdata),
    .wdata_o  (al_wdata_c),
    .wstrb_o  (al_wstrb_c)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  // Misaligned half/word accesses never reach the bus
  assign addr_err_c = ((req_size == SZ_HALF) & req_addr[0]) |
                      ((req_size == SZ_WORD) & (req_addr[1:0] != 2'b00));
`else
  assign addr_err_c = 1'b0;
`endif

  assign idle_req_c = (state_q == DST_IDLE) & req_valid;

  // Next-state logic; a flush racing a completed data phase simply drops the data
  always_comb begin
    state_d   = state_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;
    case (state_q)
      DST_IDLE: begin
        if (req_valid && !flush && !addr_err_c) begin
          state_d  = DST_ADDR;
          accept_c = 1'b1;
        end
      end
      DST_ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            if (flush) begin
              state_d = DST_IDLE;
            end else begin
              state_d   = DST_HOLD;
              capture_c = 1'b1;
            end
          end else if (flush) begin
            state_d = DST_CANCEL;
          end else begin
            state_d = DST_DATA;
          end
        end else if (flush) begin
          state_d = DST_IDLE;
        end
      end
      DST_DATA: begin
        if (data_data_ok) begin
          if (flush) begin
            state_d = DST_IDLE;
          end else begin
            state_d   = DST_HOLD;
            capture_c = 1'b1;
          end
        end else if (flush) begin
          state_d = DST_CANCEL;
        end
      end
      DST_HOLD: begin
        if (pipe_adv || flush) state_d = DST_IDLE;
      end
      DST_CANCEL: begin
        if (data_data_ok) state_d = DST_IDLE;
      end
      default: state_d = DST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= DST_IDLE;
    else     state_q <= state_d;
  end

  // Bus fields latched on accept, request/done flags and captured read word
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q      <= '0;
      data_req_q <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      data_req_q <= (state_d == DST_ADDR);
      done_q     <= (state_d == DST_HOLD);
      if (accept_c) begin
        bus_q.wr    <= req_we;
        bus_q.size  <= req_size;
        bus_q.addr  <= req_addr;
        bus_q.wdata <= al_wdata_c;
        bus_q.wstrb <= al_wstrb_c;
      end
      if (capture_c) rdata_q <= data_rdata;
    end
  end

  assign data_req   = data_req_q;
  assign data_wr    = bus_q.wr;
  assign data_size  = bus_q.size;
  assign data_addr  = bus_q.addr;
  assign data_wdata = bus_q.wdata;
  assign data_wstrb = bus_q.wstrb;
  assign rdata      = rdata_q;
  assign done       = done_q;

  assign stall = (idle_req_c & ~flush & ~addr_err_c) |
                 (state_q == DST_ADDR) | (state_q == DST_DATA) |
                 (state_q == DST_CANCEL);
  assign adel  = idle_req_c & addr_err_c & ~req_we;
  assign ades  = idle_req_c & addr_err_c & req_we;

endmodule
